// File: rtl/itch_msg_parser_pkg.sv
// Shared constants, state encoding and type helpers for the ITCH 5.0 message parser.
// Offsets count from the message type byte, which is offset 0.
package itch_msg_parser_pkg;

   localparam logic [7:0] ITCH_ADD  = 8'h41;
   localparam logic [7:0] ITCH_DEL  = 8'h44;
   localparam logic [7:0] ITCH_EXEC = 8'h45;
   localparam logic [7:0] SIDE_BUY  = 8'h42;

   localparam logic [15:0] ITCH_ADD_LEN  = 16'd36;
   localparam logic [15:0] ITCH_DEL_LEN  = 16'd19;
   localparam logic [15:0] ITCH_EXEC_LEN = 16'd31;

   localparam logic [15:0] OFF_LOC_FIRST      = 16'd1;
   localparam logic [15:0] OFF_LOC_LAST       = 16'd2;
   localparam logic [15:0] OFF_REF_FIRST      = 16'd11;
   localparam logic [15:0] OFF_REF_LAST       = 16'd18;
   localparam logic [15:0] OFF_ADD_SIDE       = 16'd19;
   localparam logic [15:0] OFF_ADD_SHR_FIRST  = 16'd20;
   localparam logic [15:0] OFF_ADD_SHR_LAST   = 16'd23;
   localparam logic [15:0] OFF_ADD_PRC_FIRST  = 16'd32;
   localparam logic [15:0] OFF_ADD_PRC_LAST   = 16'd35;
   localparam logic [15:0] OFF_EXEC_SHR_FIRST = 16'd19;
   localparam logic [15:0] OFF_EXEC_SHR_LAST  = 16'd22;

   typedef enum logic [2:0] {LEN_HI, LEN_LO, TYPE, BODY, SKIP} parserStateType;

   function automatic logic is_decoded(input logic [7:0] t);
      return (t == ITCH_ADD) || (t == ITCH_DEL) || (t == ITCH_EXEC);
   endfunction

   function automatic logic [15:0] min_len(input logic [7:0] t);
      case (t)
         ITCH_ADD:  return ITCH_ADD_LEN;
         ITCH_DEL:  return ITCH_DEL_LEN;
         ITCH_EXEC: return ITCH_EXEC_LEN;
         default:   return 16'd0;
      endcase
   endfunction

endpackage

// File: rtl/itch_msg_parser.sv
// MoldUDP64 block framer + ITCH 5.0 decoder for Add / Delete / Executed messages.
// Fields shift into shadow registers and are copied to the outputs only when a strobe fires.
module itch_msg_parser
   import itch_msg_parser_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clkIn,
   input  logic                 rstIn,
   input  logic [7:0]           dataIn,
   input  logic                 dataValidIn,
   input  logic                 lastIn,
   output logic                 addValidOut,
   output logic                 delValidOut,
   output logic                 execValidOut,
   output logic [63:0]          refNumOut,
   output logic [15:0]          locateOut,
   output logic [31:0]          priceOut,
   output logic [31:0]          sharesOut,
   output logic                 buySellOut,
   output logic [CNT_WIDTH-1:0] dropCntOut
);

   parserStateType state;
   logic [15:0] len;
   logic [15:0] idx;
   logic [7:0]  msg_type;

   logic [63:0] sh_ref,   sh_ref_n;
   logic [15:0] sh_loc,   sh_loc_n;
   logic [31:0] sh_price, sh_price_n;
   logic [31:0] sh_shr,   sh_shr_n;
   logic        sh_side,  sh_side_n;

   logic [15:0] idx_nxt;
   logic [15:0] new_len;

   assign idx_nxt = idx + 16'd1;
   assign new_len = {len[15:8], dataIn};

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Next shadow values include the byte being accepted, so a field ending on the final byte is complete at fire time.
   always_comb begin
      sh_ref_n   = sh_ref;
      sh_loc_n   = sh_loc;
      sh_price_n = sh_price;
      sh_shr_n   = sh_shr;
      sh_side_n  = sh_side;
      if (dataValidIn && state == BODY) begin
         if (idx >= OFF_LOC_FIRST && idx <= OFF_LOC_LAST)
            sh_loc_n = {sh_loc[7:0], dataIn};
         if (idx >= OFF_REF_FIRST && idx <= OFF_REF_LAST)
            sh_ref_n = {sh_ref[55:0], dataIn};
         if (msg_type == ITCH_ADD) begin
            if (idx == OFF_ADD_SIDE)
               sh_side_n = (dataIn == SIDE_BUY);
            if (idx >= OFF_ADD_SHR_FIRST && idx <= OFF_ADD_SHR_LAST)
               sh_shr_n = {sh_shr[23:0], dataIn};
            if (idx >= OFF_ADD_PRC_FIRST && idx <= OFF_ADD_PRC_LAST)
               sh_price_n = {sh_price[23:0], dataIn};
         end else if (msg_type == ITCH_EXEC) begin
            if (idx >= OFF_EXEC_SHR_FIRST && idx <= OFF_EXEC_SHR_LAST)
               sh_shr_n = {sh_shr[23:0], dataIn};
         end
      end
   end

   always_ff @(posedge clkIn) begin
      if (!rstIn) begin
         state        <= LEN_HI;
         len          <= '0;
         idx          <= '0;
         msg_type     <= '0;
         sh_ref       <= '0;
         sh_loc       <= '0;
         sh_price     <= '0;
         sh_shr       <= '0;
         sh_side      <= 1'b0;
         addValidOut  <= 1'b0;
         delValidOut  <= 1'b0;
         execValidOut <= 1'b0;
         refNumOut    <= '0;
         locateOut    <= '0;
         priceOut     <= '0;
         sharesOut    <= '0;
         buySellOut   <= 1'b0;
         dropCntOut   <= '0;
      end else begin
         addValidOut  <= 1'b0;
         delValidOut  <= 1'b0;
         execValidOut <= 1'b0;
         sh_ref       <= sh_ref_n;
         sh_loc       <= sh_loc_n;
         sh_price     <= sh_price_n;
         sh_shr       <= sh_shr_n;
         sh_side      <= sh_side_n;
         if (dataValidIn) begin
            unique case (state)
               LEN_HI: begin
                  len <= {dataIn, 8'h00};
                  if (lastIn) begin
                     dropCntOut <= sat_inc(dropCntOut);
                     state      <= LEN_HI;
                  end else begin
                     state <= LEN_LO;
                  end
               end
               LEN_LO: begin
                  len <= new_len;
                  // An empty block that ends the payload is complete, not truncated.
                  if (lastIn) begin
                     if (new_len != 16'd0) dropCntOut <= sat_inc(dropCntOut);
                     state <= LEN_HI;
                  end else begin
                     state <= (new_len == 16'd0) ? LEN_HI : TYPE;
                  end
               end
               TYPE: begin
                  msg_type <= dataIn;
                  idx      <= 16'd1;
                  if (len == 16'd1) begin
                     if (is_decoded(dataIn)) dropCntOut <= sat_inc(dropCntOut);
                     state <= LEN_HI;
                  end else if (lastIn) begin
                     dropCntOut <= sat_inc(dropCntOut);
                     state      <= LEN_HI;
                  end else begin
                     state <= is_decoded(dataIn) ? BODY : SKIP;
                  end
               end
               BODY: begin
                  idx <= idx_nxt;
                  if (idx_nxt == len) begin
                     state <= LEN_HI;
                     if (len >= min_len(msg_type)) begin
                        refNumOut <= sh_ref_n;
                        locateOut <= sh_loc_n;
                        unique case (msg_type)
                           ITCH_ADD: begin
                              addValidOut <= 1'b1;
                              priceOut    <= sh_price_n;
                              sharesOut   <= sh_shr_n;
                              buySellOut  <= sh_side_n;
                           end
                           ITCH_EXEC: begin
                              execValidOut <= 1'b1;
                              sharesOut    <= sh_shr_n;
                           end
                           default: delValidOut <= 1'b1;
                        endcase
                     end else begin
                        dropCntOut <= sat_inc(dropCntOut);
                     end
                  end else if (lastIn) begin
                     dropCntOut <= sat_inc(dropCntOut);
                     state      <= LEN_HI;
                  end
               end
               SKIP: begin
                  idx <= idx_nxt;
                  if (idx_nxt == len) begin
                     state <= LEN_HI;
                  end else if (lastIn) begin
                     dropCntOut <= sat_inc(dropCntOut);
                     state      <= LEN_HI;
                  end
               end
               default: state <= LEN_HI;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_itch_msg_parser.sv
// Directed bench for itch_msg_parser: the stimulus side queues expected strobes,
// a negedge monitor pops and compares them whenever a strobe is seen.
module tb_itch_msg_parser;
   import itch_msg_parser_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  data;
   logic        data_valid;
   logic        last;
   logic        add_v, del_v, exec_v;
   logic [63:0] ref_num;
   logic [15:0] locate;
   logic [31:0] price;
   logic [31:0] shares;
   logic        buy_sell;
   logic [15:0] drop_cnt;

   always #5 clk = ~clk;

   itch_msg_parser #(.CNT_WIDTH(16)) dut (
      .clkIn(clk), .rstIn(rst_n), .dataIn(data), .dataValidIn(data_valid), .lastIn(last),
      .addValidOut(add_v), .delValidOut(del_v), .execValidOut(exec_v),
      .refNumOut(ref_num), .locateOut(locate), .priceOut(price), .sharesOut(shares),
      .buySellOut(buy_sell), .dropCntOut(drop_cnt)
   );

   typedef struct {
      logic [1:0]  kind;
      logic [63:0] r;
      logic [15:0] loc;
      logic [31:0] prc;
      logic [31:0] shr;
      logic        side;
   } exp_t;

   exp_t exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] cur_ref;
   logic [15:0] cur_loc;
   logic [31:0] cur_prc, cur_shr;
   logic        cur_side;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic logic [1:0] kind_code(input logic [7:0] t);
      case (t)
         ITCH_ADD:  return 2'd1;
         ITCH_DEL:  return 2'd2;
         ITCH_EXEC: return 2'd3;
         default:   return 2'd0;
      endcase
   endfunction

   function automatic logic [1:0] seen_kind();
      return add_v ? 2'd1 : del_v ? 2'd2 : exec_v ? 2'd3 : 2'd0;
   endfunction

   task automatic model_reset();
      cur_ref = '0; cur_loc = '0; cur_prc = '0; cur_shr = '0; cur_side = 1'b0;
   endtask

   // Stream indices: 0/1 = length prefix, k+2 = message byte k. Bytes 0..end_i are sent.
   task automatic send_msg(input logic [7:0] kind, input int len, input logic [63:0] r,
                           input logic [15:0] loc, input logic [7:0] side,
                           input logic [31:0] shr, input logic [31:0] prc,
                           input int end_i, input bit last_flag, input bit gaps,
                           input bit expect_strobe, input bit tchk);
      logic [7:0]  m [0:63];
      logic [15:0] l16;
      exp_t        e;
      l16 = 16'(len);
      for (int i = 0; i < 64; i++) m[i] = 8'hC0 ^ 8'(i);
      m[0] = kind; m[1] = loc[15:8]; m[2] = loc[7:0];
      for (int i = 0; i < 8; i++) m[11+i] = r[63-8*i -: 8];
      if (kind == ITCH_ADD) begin
         m[19] = side;
         for (int i = 0; i < 4; i++) m[20+i] = shr[31-8*i -: 8];
         for (int i = 0; i < 4; i++) m[32+i] = prc[31-8*i -: 8];
      end else if (kind == ITCH_EXEC) begin
         for (int i = 0; i < 4; i++) m[19+i] = shr[31-8*i -: 8];
      end
      if (expect_strobe) begin
         cur_ref = r; cur_loc = loc;
         if (kind == ITCH_ADD) begin
            cur_prc = prc; cur_shr = shr; cur_side = (side == 8'h42);
         end else if (kind == ITCH_EXEC) begin
            cur_shr = shr;
         end
         e.kind = kind_code(kind); e.r = cur_ref; e.loc = cur_loc;
         e.prc = cur_prc; e.shr = cur_shr; e.side = cur_side;
         exp_q.push_back(e);
      end
      for (int i = 0; i <= end_i; i++) begin
         if (gaps && (i % 2 == 1)) begin
            @(negedge clk);
            data_valid = 1'b0; last = 1'b0;
         end
         @(negedge clk);
         data       = (i == 0) ? l16[15:8] : (i == 1) ? l16[7:0] : m[i-2];
         data_valid = 1'b1;
         last       = last_flag && (i == end_i);
      end
      @(negedge clk);
      data_valid = 1'b0; last = 1'b0;
      if (tchk) chk("strobe_timing", 64'(seen_kind()), expect_strobe ? 64'(kind_code(kind)) : 64'd0);
   endtask

   initial begin : monitor
      forever begin
         exp_t e;
         int   ns;
         @(negedge clk);
         ns = int'(add_v) + int'(del_v) + int'(exec_v);
         if (ns != 0) begin
            chk("one_strobe", 64'(ns), 64'd1);
            if (exp_q.size() == 0) begin
               chk("unexpected_strobe", 64'(seen_kind()), 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("kind",   64'(seen_kind()), 64'(e.kind));
               chk("refNum", ref_num,          e.r);
               chk("locate", 64'(locate),      64'(e.loc));
               chk("price",  64'(price),       64'(e.prc));
               chk("shares", 64'(shares),      64'(e.shr));
               chk("side",   64'(buy_sell),    64'(e.side));
            end
         end
      end
   end

   task automatic chk_all_zero(input string nm);
      chk({nm, "_strobes"}, 64'({add_v, del_v, exec_v}), 64'd0);
      chk({nm, "_ref"},     ref_num,                     64'd0);
      chk({nm, "_loc"},     64'(locate),                 64'd0);
      chk({nm, "_price"},   64'(price),                  64'd0);
      chk({nm, "_shares"},  64'(shares),                 64'd0);
      chk({nm, "_side"},    64'(buy_sell),               64'd0);
      chk({nm, "_drop"},    64'(drop_cnt),               64'd0);
   endtask

   initial begin : stim
      rst_n = 1'b0; data = '0; data_valid = 1'b0; last = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Add, exact minimum length
      send_msg(ITCH_ADD, 36, 64'h1E240, 16'h0007, 8'h42, 32'd100, 32'd1250000, 37, 1, 0, 1, 1);

      // Delete then Exec back-to-back in one payload; Exec keeps Add's price/side
      send_msg(ITCH_DEL, 19, 64'h1234_5678_9ABC_DEF0, 16'h0011, 8'h00, 32'd0, 32'd0, 20, 0, 0, 1, 0);
      send_msg(ITCH_EXEC, 31, 64'h1234_5678_9ABC_DEF0, 16'h0011, 8'h00, 32'd50, 32'd0, 32, 1, 0, 1, 1);

      // Unknown 'R' between two Adds, 50% valid duty
      send_msg(ITCH_ADD, 36, 64'hA1, 16'h0003, 8'h53, 32'd200, 32'd990000, 37, 0, 1, 1, 1);
      send_msg(8'h52, 39, 64'h0, 16'h0000, 8'h00, 32'd0, 32'd0, 40, 0, 1, 0, 1);
      send_msg(ITCH_ADD, 36, 64'hA2, 16'h0004, 8'h42, 32'd300, 32'd1010000, 37, 1, 1, 1, 1);
      chk("drop_after_unknown", 64'(drop_cnt), 64'd0);

      // Short Add and short Exec are dropped
      send_msg(ITCH_ADD, 20, 64'hBAD, 16'h0001, 8'h42, 32'd1, 32'd1, 21, 1, 0, 0, 1);
      chk("drop_short_add", 64'(drop_cnt), 64'd1);
      send_msg(ITCH_EXEC, 30, 64'hBAD, 16'h0001, 8'h00, 32'd1, 32'd0, 31, 1, 0, 0, 1);
      chk("drop_short_exec", 64'(drop_cnt), 64'd2);

      // Long Add: trailing bytes ignored; unrecognised side byte means sell
      send_msg(ITCH_ADD, 40, 64'hFEDC_BA98_7654_3210, 16'hBEEF, 8'h58, 32'd7, 32'h7FFF_FFFF, 41, 1, 0, 1, 1);

      // lastIn on message byte 10 of a Delete, then a clean Delete
      send_msg(ITCH_DEL, 19, 64'h99, 16'h0009, 8'h00, 32'd0, 32'd0, 12, 1, 0, 0, 1);
      chk("drop_truncated_del", 64'(drop_cnt), 64'd3);
      send_msg(ITCH_DEL, 19, 64'h55, 16'h0009, 8'h00, 32'd0, 32'd0, 20, 1, 0, 1, 1);

      // Prefix-only fragment
      send_msg(ITCH_ADD, 36, 64'h0, 16'h0000, 8'h00, 32'd0, 32'd0, 0, 1, 0, 0, 1);
      chk("drop_prefix_fragment", 64'(drop_cnt), 64'd4);

      // Reset mid-Add, then a full Add
      send_msg(ITCH_ADD, 36, 64'h77, 16'h0002, 8'h42, 32'd9, 32'd9, 20, 0, 0, 0, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      chk_all_zero("mid_reset");
      send_msg(ITCH_ADD, 36, 64'h0102_0304_0506_0708, 16'h1234, 8'h42, 32'd1000, 32'd5000, 37, 1, 0, 1, 1);
      chk("drop_after_reset", 64'(drop_cnt), 64'd0);

      repeat (5) @(negedge clk);
      chk("pending_expected", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
